// File: rtl/pack_telemetry_pkg.sv
// Shared telemetry link constants and FSM encoding, used by both the framer and the link receiver.
package pack_telemetry_pkg;

  localparam int               TELEM_BYTES = 11;
  localparam int               WORD_W      = 8 * TELEM_BYTES;
  localparam logic [7:0]       K_COMMA     = 8'hBC;
  localparam int               CNT_W       = 4;
  localparam logic [CNT_W-1:0] LAST_BYTE   = CNT_W'(TELEM_BYTES - 1);

  typedef enum logic {
    IDLE = 1'b0,
    DATA = 1'b1
  } telem_state_t;

endpackage

// File: rtl/pack_telemetry_if.sv
// Word handshake on the upstream side and symbol stream towards the 8b10b encoder.
interface pack_telemetry_if;
  import pack_telemetry_pkg::*;

  logic [WORD_W-1:0] data_in;
  logic              valid_in;
  logic              ready_out;
  logic              ce_in;
  logic [7:0]        data_out;
  logic              k_out;
  logic              valid_out;

  modport master (
    output data_in, valid_in, ce_in,
    input  ready_out, data_out, k_out, valid_out
  );

  modport slave (
    input  data_in, valid_in, ce_in,
    output ready_out, data_out, k_out, valid_out
  );

endinterface

// File: rtl/pack_telemetry_sat_cnt16.sv
// 16-bit event counter that sticks at all-ones instead of wrapping.
module sat_cnt16 (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        inc,
  output logic [15:0] cnt
);

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (inc) begin
      cnt <= sat_inc(cnt);
    end
  end

endmodule

// File: rtl/pack_telemetry.sv
// Telemetry framer: K comma, then 11 data bytes LSB first; idle Ks fill every gap.
// Optional saturating packet/overflow statistics under PACK_TELEMETRY_STATS_EN.
module pack_telemetry
  import pack_telemetry_pkg::*;
#(
  parameter int         g_data_width = TELEM_BYTES,
  parameter logic [7:0] g_k_char     = K_COMMA
) (
  input  logic              clk,
  input  logic              rst_n,
  pack_telemetry_if.slave   bus,
  output logic [15:0]       pkt_cnt,
  output logic [15:0]       ovr_cnt
);

  if (g_data_width != TELEM_BYTES) begin : g_width_check
    $fatal(1, "pack_telemetry: g_data_width must be 11");
  end

  function automatic logic [7:0] pick_byte(input logic [WORD_W-1:0] w,
                                           input logic [CNT_W-1:0]  idx);
    return w[{idx, 3'b000} +: 8];
  endfunction

  telem_state_t      state;
  logic [CNT_W-1:0]  cnt;
  logic              hold_full;
  logic [WORD_W-1:0] hold_word;
  logic [WORD_W-1:0] shift_word;
  logic              accept;
  logic              take;
  logic              last_beat;

  assign accept        = bus.valid_in && bus.ready_out;
  assign take          = bus.ce_in && (state == IDLE) && hold_full;
  assign last_beat     = bus.ce_in && (state == DATA) && (cnt == LAST_BYTE);
  assign bus.ready_out = !hold_full;

  // Control path and registered symbol outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      cnt           <= '0;
      hold_full     <= 1'b0;
      bus.data_out  <= 8'h00;
      bus.k_out     <= 1'b0;
      bus.valid_out <= 1'b0;
    end else begin
      bus.valid_out <= bus.ce_in;
      if (accept) begin
        hold_full <= 1'b1;
      end else if (take) begin
        hold_full <= 1'b0;
      end
      if (bus.ce_in) begin
        case (state)
          IDLE: begin
            bus.data_out <= g_k_char;
            bus.k_out    <= 1'b1;
            if (hold_full) begin
              cnt   <= '0;
              state <= DATA;
            end
          end
          DATA: begin
            bus.data_out <= pick_byte(shift_word, cnt);
            bus.k_out    <= 1'b0;
            if (cnt == LAST_BYTE) begin
              cnt   <= '0;
              state <= IDLE;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  // Payload storage: holding entry, then the shift word for the packet in flight
  always_ff @(posedge clk) begin
    if (accept) begin
      hold_word <= bus.data_in;
    end
    if (take) begin
      shift_word <= hold_word;
    end
  end

`ifdef PACK_TELEMETRY_STATS_EN
  sat_cnt16 u_pkt_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (last_beat),
    .cnt   (pkt_cnt)
  );

  sat_cnt16 u_ovr_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (bus.valid_in && !bus.ready_out),
    .cnt   (ovr_cnt)
  );
`else
  assign pkt_cnt = 16'h0000;
  assign ovr_cnt = 16'h0000;
`endif

endmodule

// File: tb/tb_pack_telemetry.sv
// Directed bench for pack_telemetry with a loopback receiver and an expected-word scoreboard.
module tb_pack_telemetry;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [15:0] pkt_cnt;
  logic [15:0] ovr_cnt;

  pack_telemetry_if bus ();

  pack_telemetry dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .bus     (bus),
    .pkt_cnt (pkt_cnt),
    .ovr_cnt (ovr_cnt)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  logic [87:0] exp_q[$];
  logic [87:0] rx_word   = '0;
  int          rx_cnt    = 0;
  int          rx_words  = 0;
  logic [8:0]  last_sym  = '0;
  logic        ce_seen;
  bit          ce_rand   = 1'b0;

  task automatic chk(input string tag, input logic [87:0] obs, input logic [87:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) ce_seen <= 1'b0;
    else        ce_seen <= bus.ce_in;
  end

  // Loopback receiver: collects bytes between Ks and commits a word on the closing K
  always @(negedge clk) begin
    if (!rst_n) begin
      last_sym = '0;
    end else begin
      chk("valid_after_ce", 88'(bus.valid_out), 88'(ce_seen));
      if (bus.valid_out) begin
        if (bus.k_out) begin
          chk("k_char", 88'(bus.data_out), 88'hBC);
          if (rx_cnt == 11) begin
            chk("rx_expected_pending", 88'(exp_q.size() != 0), 88'h1);
            if (exp_q.size() != 0) chk("rx_word", rx_word, exp_q.pop_front());
            rx_words++;
          end
          rx_cnt = 0;
        end else begin
          chk("frame_len", 88'(rx_cnt < 11), 88'h1);
          if (rx_cnt < 11) rx_word[8*rx_cnt +: 8] = bus.data_out;
          rx_cnt++;
        end
      end else begin
        chk("hold_out", 88'({bus.k_out, bus.data_out}), 88'(last_sym));
      end
      last_sym = {bus.k_out, bus.data_out};
    end
  end

  task automatic step();
    @(negedge clk);
    if (ce_rand) bus.ce_in = 1'($urandom_range(0, 1));
  endtask

  task automatic offer(input logic [87:0] w);
    bit done = 1'b0;
    bus.data_in  = w;
    bus.valid_in = 1'b1;
    for (int i = 0; i < 200 && !done; i++) begin
      if (bus.ready_out) begin
        exp_q.push_back(w);
        done = 1'b1;
      end
      step();
    end
    bus.valid_in = 1'b0;
    chk("offer_accepted", 88'(done), 88'h1);
    chk("ready_drop", 88'(bus.ready_out), 88'h0);
  endtask

  task automatic wait_rx(input int n);
    for (int i = 0; i < 600 && rx_words < n; i++) step();
    chk("rx_count", 88'(rx_words), 88'(n));
  endtask

  localparam logic [87:0] W1 = 88'h0A_09_08_07_06_05_04_03_02_01_00;
  localparam logic [87:0] W2 = 88'hDEADBEEF_CAFEBABE_123456;
  localparam logic [87:0] W3 = 88'h0123456789_ABCDEF_FEDCBA;
  localparam logic [87:0] W4 = 88'hBCBCBC_0000_FFFF_BC00BC_11;
  localparam logic [87:0] W5 = 88'h55AA55AA_55AA55AA_55AA55;
  localparam logic [87:0] W6 = 88'h6666_7777_8888_9999_AAAA_BB;
  localparam logic [87:0] W7 = 88'h7E7E7E7E_81818181_C3C3C3;

  initial begin
    int nbytes;
    int base;
    bit found;
    bus.ce_in    = 1'b0;
    bus.valid_in = 1'b0;
    bus.data_in  = '0;
    #1 rst_n = 1'b0;
    #10;
    chk("rst_data_out", 88'(bus.data_out), 88'h0);
    chk("rst_k_out", 88'(bus.k_out), 88'h0);
    chk("rst_valid_out", 88'(bus.valid_out), 88'h0);
    chk("rst_ready_out", 88'(bus.ready_out), 88'h1);
    chk("rst_pkt_cnt", 88'(pkt_cnt), 88'h0);
    chk("rst_ovr_cnt", 88'(ovr_cnt), 88'h0);
    step();
    #2 rst_n = 1'b1;

    // Idle stream of Ks
    bus.ce_in = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("idle_valid", 88'(bus.valid_out), 88'h1);
      chk("idle_k", 88'(bus.k_out), 88'h1);
      chk("idle_data", 88'(bus.data_out), 88'hBC);
      chk("idle_ready", 88'(bus.ready_out), 88'h1);
    end

    // Single packet, exact byte sequence
    offer(W1);
    found = 1'b0;
    for (int i = 0; i < 30 && !found; i++) begin
      if (bus.valid_out && !bus.k_out) found = 1'b1;
      else step();
    end
    chk("pkt1_start_found", 88'(found), 88'h1);
    chk("pkt1_byte0", 88'({bus.k_out, bus.data_out}), 88'h000);
    for (int i = 1; i < 11; i++) begin
      step();
      chk("pkt1_byte", 88'({bus.k_out, bus.data_out}), 88'(i));
    end
    step();
    chk("pkt1_end_k", 88'({bus.k_out, bus.data_out}), 88'h1BC);
    wait_rx(1);

    // Back-to-back words
    offer(W2);
    offer(W3);
    for (int i = 0; i < 5; i++) begin
      step();
      chk("b2b_ready_low", 88'(bus.ready_out), 88'h0);
    end
    wait_rx(3);
`ifdef PACK_TELEMETRY_STATS_EN
    chk("pkt_cnt_b2b", 88'(pkt_cnt), 88'd3);
`else
    chk("pkt_cnt_b2b", 88'(pkt_cnt), 88'd0);
`endif

    // Random ce gaps
    ce_rand = 1'b1;
    offer(W4);
    offer(W5);
    wait_rx(5);
    ce_rand = 1'b0;
    bus.ce_in = 1'b1;
`ifdef PACK_TELEMETRY_STATS_EN
    chk("pkt_cnt_gaps", 88'(pkt_cnt), 88'd5);
`else
    chk("pkt_cnt_gaps", 88'(pkt_cnt), 88'd0);
`endif

    // Reset after byte 5 of a packet
    base = rx_words;
    offer(W6);
    nbytes = 0;
    for (int i = 0; i < 40 && nbytes < 6; i++) begin
      step();
      if (bus.valid_out && !bus.k_out) nbytes++;
    end
    chk("trunc_bytes_seen", 88'(nbytes), 88'd6);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_data", 88'(bus.data_out), 88'h0);
    chk("async_rst_k", 88'(bus.k_out), 88'h0);
    chk("async_rst_valid", 88'(bus.valid_out), 88'h0);
    chk("async_rst_ready", 88'(bus.ready_out), 88'h1);
    chk("async_rst_pkt", 88'(pkt_cnt), 88'h0);
    step();
    step();
    #2 rst_n = 1'b1;
    void'(exp_q.pop_front());
    for (int i = 0; i < 15; i++) begin
      step();
      chk("post_rst_idle", 88'({bus.valid_out, bus.k_out, bus.data_out}), 88'h3BC);
    end
    chk("trunc_no_word", 88'(rx_words), 88'(base));

    // Overflow: word parked in holding register while ce is low
    bus.ce_in = 1'b0;
    offer(W7);
    bus.valid_in = 1'b1;
    bus.data_in  = 88'hFFFF_FFFF_FFFF_FFFF_FFFF_FF;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("ovr_ready_low", 88'(bus.ready_out), 88'h0);
    end
    bus.valid_in = 1'b0;
    bus.ce_in    = 1'b1;
    wait_rx(base + 1);
`ifdef PACK_TELEMETRY_STATS_EN
    chk("ovr_cnt", 88'(ovr_cnt), 88'd3);
    chk("pkt_cnt_after_rst", 88'(pkt_cnt), 88'd1);
`else
    chk("ovr_cnt", 88'(ovr_cnt), 88'd0);
    chk("pkt_cnt_after_rst", 88'(pkt_cnt), 88'd0);
`endif
    chk("scoreboard_empty", 88'(exp_q.size()), 88'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
